// File: rtl/mem_pkg.sv
// Shared types and constants for the byte-sequencing memory initiator.
// Holds the FSM state encoding, the bus direction values and the idle
// levels of the memory strobes.
package mem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BYTE0 = 2'd1,
    ST_BYTE1 = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Bus direction as seen by the memory block.
  localparam logic DIR_TO_MEM   = 1'b0;
  localparam logic DIR_FROM_MEM = 1'b1;

  // Strobe levels while no byte cycle is in progress.
  localparam logic IDLE_LOAD     = 1'b0;
  localparam logic IDLE_ASSERT_N = 1'b1;

endpackage

// File: rtl/mem_master.sv
// Memory initiator: turns 8/16-bit load/store requests into little-endian byte cycles.
// Latency: rsp_valid in the 2nd (narrow) / 3rd (wide) cycle after the accept cycle.
// Backpressure: req_ready only in IDLE; the response is held until rsp_ready.
module mem_master
  import mem_pkg::*;
#(
  parameter int WIDTH_ADDR = 16,
  parameter int WIDTH      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic                  req_wide,
  input  logic [WIDTH_ADDR-1:0] req_addr,
  input  logic [2*WIDTH-1:0]    req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [2*WIDTH-1:0]    rsp_data,
  output logic [WIDTH_ADDR-1:0] mem_addr,
  output logic                  mem_bus_dir,
  output logic [WIDTH-1:0]      mem_wdata,
  output logic                  mem_load,
  output logic                  mem_assert_n,
  input  logic [WIDTH-1:0]      mem_rdata
);

  state_t                r_state;
  logic                  r_write;
  logic                  r_wide;
  logic [WIDTH_ADDR-1:0] r_addr;
  logic [WIDTH-1:0]      r_wdata_hi;
  logic                  r_req_ready;
  logic                  r_rsp_valid;
  logic [2*WIDTH-1:0]    r_rsp_data;
  logic [WIDTH_ADDR-1:0] r_mem_addr;
  logic                  r_mem_dir;
  logic [WIDTH-1:0]      r_mem_wdata;
  logic                  r_mem_load;
  logic                  r_mem_assert_n;

  // Address of the high byte; the adder width gives modulo-2^WIDTH_ADDR wrap.
  logic [WIDTH_ADDR-1:0] w_addr_inc;
  assign w_addr_inc = r_addr + {{(WIDTH_ADDR-1){1'b0}}, 1'b1};

  // Request/response sequencing with all memory-side outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= ST_IDLE;
      r_write        <= 1'b0;
      r_wide         <= 1'b0;
      r_addr         <= '0;
      r_wdata_hi     <= '0;
      r_req_ready    <= 1'b1;
      r_rsp_valid    <= 1'b0;
      r_rsp_data     <= '0;
      r_mem_addr     <= '0;
      r_mem_dir      <= DIR_FROM_MEM;
      r_mem_wdata    <= '0;
      r_mem_load     <= IDLE_LOAD;
      r_mem_assert_n <= IDLE_ASSERT_N;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_write     <= req_write;
            r_wide      <= req_wide;
            r_addr      <= req_addr;
            r_wdata_hi  <= req_wdata[2*WIDTH-1:WIDTH];
            r_req_ready <= 1'b0;
            r_rsp_data  <= '0;
            r_mem_addr  <= req_addr;
            if (req_write) begin
              r_mem_dir      <= DIR_TO_MEM;
              r_mem_load     <= 1'b1;
              r_mem_wdata    <= req_wdata[WIDTH-1:0];
              r_mem_assert_n <= IDLE_ASSERT_N;
            end else begin
              r_mem_dir      <= DIR_FROM_MEM;
              r_mem_load     <= IDLE_LOAD;
              r_mem_wdata    <= '0;
              r_mem_assert_n <= 1'b0;
            end
            r_state <= ST_BYTE0;
          end
        end
        ST_BYTE0: begin
          if (!r_write) begin
            r_rsp_data[WIDTH-1:0] <= mem_rdata;
          end
          if (r_wide) begin
            // Keep direction and strobes; only address and store byte change.
            r_mem_addr  <= w_addr_inc;
            r_mem_wdata <= r_write ? r_wdata_hi : '0;
            r_state     <= ST_BYTE1;
          end else begin
            r_mem_addr     <= '0;
            r_mem_dir      <= DIR_FROM_MEM;
            r_mem_wdata    <= '0;
            r_mem_load     <= IDLE_LOAD;
            r_mem_assert_n <= IDLE_ASSERT_N;
            r_rsp_valid    <= 1'b1;
            r_state        <= ST_RESP;
          end
        end
        ST_BYTE1: begin
          if (!r_write) begin
            r_rsp_data[2*WIDTH-1:WIDTH] <= mem_rdata;
          end
          r_mem_addr     <= '0;
          r_mem_dir      <= DIR_FROM_MEM;
          r_mem_wdata    <= '0;
          r_mem_load     <= IDLE_LOAD;
          r_mem_assert_n <= IDLE_ASSERT_N;
          r_rsp_valid    <= 1'b1;
          r_state        <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_req_ready <= 1'b1;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready    = r_req_ready;
  assign rsp_valid    = r_rsp_valid;
  assign rsp_data     = r_rsp_data;
  assign mem_addr     = r_mem_addr;
  assign mem_bus_dir  = r_mem_dir;
  assign mem_wdata    = r_mem_wdata;
  assign mem_assert_n = r_mem_assert_n;
  // A reset landing on a store byte cycle must not commit that byte, so the
  // write strobe is masked by reset before the memory samples it.
  assign mem_load     = r_mem_load & ~reset;

endmodule

// File: tb/tb_mem_master.sv
// Directed bench for mem_master with a behavioural byte memory as responder.
module tb_mem_master;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_wide;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_data;
  logic [15:0] mem_addr;
  logic        mem_bus_dir;
  logic [7:0]  mem_wdata;
  logic        mem_load;
  logic        mem_assert_n;
  logic [7:0]  mem_rdata;

  logic [7:0]  mem [0:65535];

  int vectors     = 0;
  int miscompares = 0;
  int load_cnt    = 0;
  bit chk_en      = 1'b0;

  always #5 clk = ~clk;

  mem_master #(.WIDTH_ADDR(16), .WIDTH(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_write   (req_write),
    .req_wide    (req_wide),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .mem_addr    (mem_addr),
    .mem_bus_dir (mem_bus_dir),
    .mem_wdata   (mem_wdata),
    .mem_load    (mem_load),
    .mem_assert_n(mem_assert_n),
    .mem_rdata   (mem_rdata)
  );

  // Memory responder, DEFAULT_VALUE = 0.
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
  end
  always @(posedge clk) begin
    if (mem_load && !mem_bus_dir) mem[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_load) load_cnt++;
  end

  // Protocol checker, every cycle outside reset.
  always @(negedge clk) begin
    if (chk_en && !reset) begin
      vectors++;
      if ((mem_load && mem_bus_dir) || (!mem_assert_n && !mem_bus_dir) ||
          (req_ready && (rsp_valid || !mem_bus_dir || mem_load || !mem_assert_n))) begin
        miscompares++;
        $display("FAIL protocol: load=%0b dir=%0b assert_n=%0b req_ready=%0b rsp_valid=%0b",
                 mem_load, mem_bus_dir, mem_assert_n, req_ready, rsp_valid);
      end
    end
  end

  task automatic check_reset_vals(input string nm);
    vectors++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_data !== 16'h0000 ||
        mem_addr !== 16'h0000 || mem_bus_dir !== 1'b1 || mem_load !== 1'b0 ||
        mem_assert_n !== 1'b1 || mem_wdata !== 8'h00) begin
      miscompares++;
      $display("FAIL %s: got rr=%0b rv=%0b rd=%h ma=%h dir=%0b ld=%0b an=%0b wd=%h, need 1 0 0000 0000 1 0 1 00",
               nm, req_ready, rsp_valid, rsp_data, mem_addr, mem_bus_dir, mem_load, mem_assert_n, mem_wdata);
    end
  endtask

  // One full request/response transaction with optional response backpressure.
  task automatic run_req(input logic w, input logic wide, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic [15:0] exp,
                         input int exp_lat, input int hold, input string nm);
    int lat;
    int exp_loads;
    exp_loads = w ? (wide ? 2 : 1) : 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_wide = wide; req_addr = addr; req_wdata = wdata;
    rsp_ready = 1'b0;
    vectors++;
    if (req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s req_ready_idle: got %0b need 1", nm, req_ready);
    end
    load_cnt = 0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (rsp_valid !== 1'b1 && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    vectors++;
    if (lat !== exp_lat) begin
      miscompares++;
      $display("FAIL %s latency: got %0d need %0d", nm, lat, exp_lat);
    end
    vectors++;
    if (rsp_data !== exp) begin
      miscompares++;
      $display("FAIL %s rsp_data: got %h need %h", nm, rsp_data, exp);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      vectors++;
      if (rsp_valid !== 1'b1 || rsp_data !== exp || req_ready !== 1'b0 ||
          mem_load !== 1'b0 || mem_assert_n !== 1'b1) begin
        miscompares++;
        $display("FAIL %s hold%0d: rv=%0b rd=%h rr=%0b ld=%0b an=%0b need 1 %h 0 0 1",
                 nm, i, rsp_valid, rsp_data, req_ready, mem_load, mem_assert_n, exp);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    vectors++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s back_to_idle: rv=%0b rr=%0b need 0 1", nm, rsp_valid, req_ready);
    end
    vectors++;
    if (load_cnt !== exp_loads) begin
      miscompares++;
      $display("FAIL %s load_cycles: got %0d need %0d", nm, load_cnt, exp_loads);
    end
  endtask

  task automatic check_mem(input logic [15:0] a, input logic [7:0] exp, input string nm);
    vectors++;
    if (mem[a] !== exp) begin
      miscompares++;
      $display("FAIL %s mem[%h]: got %h need %h", nm, a, mem[a], exp);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_wide = 1'b0;
    req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset");
    reset = 1'b0;
    chk_en = 1'b1;
  endtask

  task automatic test_narrow();
    run_req(1'b1, 1'b0, 16'h0010, 16'h00A5, 16'h0000, 2, 0, "narrow_store");
    check_mem(16'h0010, 8'hA5, "narrow_store");
    check_mem(16'h0011, 8'h00, "narrow_store_hi_untouched");
    run_req(1'b0, 1'b0, 16'h0010, 16'h0000, 16'h00A5, 2, 0, "narrow_load");
  endtask

  task automatic test_wide();
    run_req(1'b1, 1'b1, 16'h0100, 16'h1234, 16'h0000, 3, 0, "wide_store");
    check_mem(16'h0100, 8'h34, "wide_store_lo");
    check_mem(16'h0101, 8'h12, "wide_store_hi");
    run_req(1'b0, 1'b1, 16'h0100, 16'h0000, 16'h1234, 3, 0, "wide_load");
    run_req(1'b0, 1'b0, 16'h0101, 16'h0000, 16'h0012, 2, 0, "narrow_load_zext");
  endtask

  task automatic test_wrap();
    run_req(1'b1, 1'b1, 16'hFFFF, 16'hBEEF, 16'h0000, 3, 0, "wrap_store");
    check_mem(16'hFFFF, 8'hEF, "wrap_lo");
    check_mem(16'h0000, 8'hBE, "wrap_hi");
    run_req(1'b0, 1'b1, 16'hFFFF, 16'h0000, 16'hBEEF, 3, 0, "wrap_load");
  endtask

  task automatic test_backpressure();
    run_req(1'b0, 1'b0, 16'h0010, 16'h0000, 16'h00A5, 2, 5, "backpressure");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_wide = 1'b1;
    req_addr = 16'h0200; req_wdata = 16'hCAFE;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (mem_addr !== 16'h0201 || mem_wdata !== 8'hCA || mem_load !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid byte1: ma=%h wd=%h ld=%0b need 0201 ca 1", mem_addr, mem_wdata, mem_load);
    end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_vals("reset_mid_outputs");
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      vectors++;
      if (rsp_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_mid no_rsp%0d: rsp_valid=%0b need 0", i, rsp_valid);
      end
    end
    check_mem(16'h0200, 8'hFE, "reset_mid_lo");
    check_mem(16'h0201, 8'h00, "reset_mid_hi");
  endtask

  initial begin
    test_reset();
    test_narrow();
    test_wide();
    test_wrap();
    test_backpressure();
    test_reset_mid();
    run_req(1'b0, 1'b1, 16'h0200, 16'h0000, 16'h00FE, 3, 0, "after_reset_load");
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
